// File: rtl/pe_acc_drain_pkg.sv
// Shared defaults and state encoding for the accumulator drain path.
// Downstream of the PE-row MAC array.
package pe_acc_drain_pkg;

    localparam int DEF_N_PE    = 8;
    localparam int DEF_ACC_W   = 32;
    localparam int DEF_OUT_W   = 8;
    localparam int DEF_SHIFT_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

endpackage

// File: rtl/pe_acc_drain_if.sv
// Valid/ready result stream from the accumulator drain to the output buffer.
// Each beat carries one requantized element, tagged with its PE index.
interface pe_acc_drain_if #(
    parameter int N_PE  = pe_acc_drain_pkg::DEF_N_PE,
    parameter int OUT_W = pe_acc_drain_pkg::DEF_OUT_W,
    localparam int IDX_W = $clog2(N_PE)
);

    logic                    out_vld;
    logic                    out_rdy;
    logic signed [OUT_W-1:0] out_data;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;
    logic                    out_sat;

    modport master (
        output out_vld,
        input  out_rdy,
        output out_data,
        output out_idx,
        output out_last,
        output out_sat
    );

    modport slave (
        input  out_vld,
        output out_rdy,
        input  out_data,
        input  out_idx,
        input  out_last,
        input  out_sat
    );

endinterface

// File: rtl/pe_acc_drain_requant.sv
// Combinational requantizer: round-half-up arithmetic right shift, then
// saturate to a signed OUT_W result. Also used by the PE-array output path.
module pe_acc_drain_requant
    import pe_acc_drain_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W
) (
    input  logic signed [ACC_W-1:0] a,
    input  logic [SHIFT_W-1:0]      s,
    output logic signed [OUT_W-1:0] data,
    output logic                    sat
);

    localparam logic signed [ACC_W:0] ONE_V = (ACC_W+1)'(1);
    localparam logic signed [ACC_W:0] MAX_V = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] MIN_V = ~MAX_V;

    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] r;

    // One extra bit of headroom so adding the half-LSB never wraps;
    // (1<<s)>>1 is the rounding constant and is zero for s==0.
    always_comb begin
        ext  = {a[ACC_W-1], a};
        rnd  = (ONE_V << s) >>> 1;
        sum  = ext + rnd;
        r    = sum >>> s;
        data = r[OUT_W-1:0];
        sat  = 1'b0;
        if (r > MAX_V) begin
            data = MAX_V[OUT_W-1:0];
            sat  = 1'b1;
        end else if (r < MIN_V) begin
            data = MIN_V[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/pe_acc_drain.sv
// Snapshots a PE row of accumulators on cap and drains the requantized
// values one per handshake, freeing the MAC row to restart immediately.
module pe_acc_drain
    import pe_acc_drain_pkg::*;
#(
    parameter int N_PE    = DEF_N_PE,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    localparam int IDX_W  = $clog2(N_PE)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cap,
    input  logic [N_PE*ACC_W-1:0]   acc_row,
    input  logic [SHIFT_W-1:0]      shift,
    output logic                    busy,
    output logic                    cap_drop,
    pe_acc_drain_if.master          out
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PE - 1);

    drain_state_t        state_reg, state_next;
    logic [IDX_W-1:0]    idx_reg, idx_next;
    logic [SHIFT_W-1:0]  shift_reg;
    logic                cap_drop_reg, cap_drop_next;
    logic [ACC_W-1:0]    acc_vec  [N_PE];
    logic [ACC_W-1:0]    snap_reg [N_PE];

    logic                vld;
    logic                hs;
    logic                at_last;
    logic                load;
    logic signed [OUT_W-1:0] rq_data;
    logic                rq_sat;

    genvar gi;
    generate
        for (gi = 0; gi < N_PE; gi++) begin : gen_unpack
            assign acc_vec[gi] = acc_row[gi*ACC_W +: ACC_W];
        end
    endgenerate

    assign vld     = (state_reg == DRAIN);
    assign hs      = vld & out.out_rdy;
    assign at_last = (idx_reg == LAST_IDX);

    // A cap arriving with the final handshake reloads without a bubble;
    // any other cap while draining is rejected and reported.
    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        load          = 1'b0;
        cap_drop_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cap) begin
                    load       = 1'b1;
                    idx_next   = '0;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (hs && at_last) begin
                    idx_next = '0;
                    if (cap) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    cap_drop_next = cap;
                    if (hs) begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            shift_reg    <= '0;
            cap_drop_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            cap_drop_reg <= cap_drop_next;
            if (load) begin
                shift_reg <= shift;
            end
        end
    end

    // Snapshot needs no reset: its contents are only visible while draining.
    always_ff @(posedge clk) begin
        if (load) begin
            snap_reg <= acc_vec;
        end
    end

    pe_acc_drain_requant #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .SHIFT_W (SHIFT_W)
    ) u_requant (
        .a    (snap_reg[idx_reg]),
        .s    (shift_reg),
        .data (rq_data),
        .sat  (rq_sat)
    );

    assign out.out_vld  = vld;
    assign out.out_data = vld ? rq_data : '0;
    assign out.out_sat  = vld & rq_sat;
    assign out.out_idx  = idx_reg;
    assign out.out_last = vld & at_last;
    assign busy         = vld;
    assign cap_drop     = cap_drop_reg;

endmodule
